// File: rtl/spi_flash_op_seq_pkg.sv
// Shared constants and types for the SPI flash operation sequencer:
// command opcodes, master commtype codes, op encodings and FSM states.
package spi_flash_op_seq_pkg;

  localparam logic [7:0] OPC_WREN = 8'h06;
  localparam logic [7:0] OPC_READ = 8'h03;
  localparam logic [7:0] OPC_PP   = 8'h02;
  localparam logic [7:0] OPC_SE   = 8'h20;
  localparam logic [7:0] OPC_RDSR = 8'h05;

  localparam logic [2:0] CT_WREN = 3'b000;
  localparam logic [2:0] CT_RDSR = 3'b001;
  localparam logic [2:0] CT_READ = 3'b010;
  localparam logic [2:0] CT_PP   = 3'b100;
  localparam logic [2:0] CT_SE   = 3'b101;

  localparam logic [6:0] NB_READ = 7'd32;
  localparam logic [6:0] NB_RDSR = 7'd8;

  typedef enum logic [1:0] {
    OP_READ = 2'd0,
    OP_PP   = 2'd1,
    OP_SE   = 2'd2,
    OP_RSVD = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WREN,
    ST_MAIN,
    ST_POLL,
    ST_GAP,
    ST_FIN
  } state_e;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_ISSUE,
    HS_WAIT
  } hs_state_e;

  typedef enum logic [2:0] {
    CMD_WREN,
    CMD_READ,
    CMD_PP,
    CMD_SE,
    CMD_RDSR
  } cmd_e;

  typedef struct packed {
    logic [2:0]  commtype;
    logic [7:0]  opcode;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [6:0]  nmiso_bits;
  } cmd_t;

  // Fields not used by a command stay zero so the master sees clean buses.
  function automatic cmd_t make_cmd(input cmd_e kind, input logic [31:0] addr,
                                    input logic [31:0] wdata);
    cmd_t c;
    c = '0;
    case (kind)
      CMD_WREN: begin
        c.opcode   = OPC_WREN;
        c.commtype = CT_WREN;
      end
      CMD_READ: begin
        c.opcode     = OPC_READ;
        c.commtype   = CT_READ;
        c.address    = addr;
        c.nmiso_bits = NB_READ;
      end
      CMD_PP: begin
        c.opcode   = OPC_PP;
        c.commtype = CT_PP;
        c.address  = addr;
        c.data_in  = wdata;
      end
      CMD_SE: begin
        c.opcode   = OPC_SE;
        c.commtype = CT_SE;
        c.address  = addr;
      end
      CMD_RDSR: begin
        c.opcode     = OPC_RDSR;
        c.commtype   = CT_RDSR;
        c.nmiso_bits = NB_RDSR;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic cmd_e main_cmd(input op_e o);
    return (o == OP_READ) ? CMD_READ : (o == OP_PP) ? CMD_PP : CMD_SE;
  endfunction

endpackage

// File: rtl/spi_cmd_hs.sv
// Single-command handshake with the SPI flash master: issue, wait for
// acceptance (tready low), then report completion when tready returns high.
module spi_cmd_hs
  import spi_flash_op_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        launch,
  input  cmd_t        launch_cmd,
  input  logic        m_tready,
  input  logic [31:0] m_data_out,
  output logic        m_validflag,
  output cmd_t        cur_cmd,
  output logic        cmd_done,
  output logic [31:0] rsp_data
);

  hs_state_e hs_state, hs_next;
  logic      valid_next;
  cmd_t      cmd_next;

  // tready is high while the master idles, so it only means completion
  // once acceptance (tready low) has been seen.
  always_comb begin
    hs_next    = hs_state;
    valid_next = m_validflag;
    cmd_next   = cur_cmd;
    if (launch) begin
      hs_next    = HS_ISSUE;
      valid_next = 1'b1;
      cmd_next   = launch_cmd;
    end else begin
      case (hs_state)
        HS_ISSUE: begin
          if (!m_tready) begin
            hs_next    = HS_WAIT;
            valid_next = 1'b0;
          end
        end
        HS_WAIT: begin
          if (m_tready) hs_next = HS_IDLE;
        end
        default: hs_next = hs_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_state    <= HS_IDLE;
      m_validflag <= 1'b0;
      cur_cmd     <= '0;
    end else begin
      hs_state    <= hs_next;
      m_validflag <= valid_next;
      cur_cmd     <= cmd_next;
    end
  end

  assign cmd_done = (hs_state == HS_WAIT) && m_tready;
  assign rsp_data = m_data_out;

endmodule

// File: rtl/spi_flash_op_seq.sv
// Sequences READ / PAGE_PROG / SECTOR_ERASE into WREN, main command and
// RDSR polling on top of the single-command SPI flash master.
module spi_flash_op_seq
  import spi_flash_op_seq_pkg::*;
#(
  parameter int unsigned POLL_MAX     = 1024,
  parameter int unsigned POLL_GAP_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] rdata,
  output logic        m_validflag,
  output logic [2:0]  m_commtype,
  output logic [7:0]  m_command,
  output logic [31:0] m_address,
  output logic [31:0] m_data_in,
  output logic [6:0]  m_nmiso_bits,
  output logic [3:0]  m_dummy,
  input  logic        m_tready,
  input  logic [31:0] m_data_out
);

  localparam logic [15:0] POLL_LIMIT = 16'(POLL_MAX);
  localparam logic [15:0] GAP_LAST   = 16'(POLL_GAP_CYC - 1);

  state_e      state, state_next;
  op_e         op_q;
  logic [31:0] addr_q, wdata_q;
  logic [15:0] poll_cnt, poll_cnt_inc, gap_cnt;

  logic        launch, cmd_done;
  cmd_t        launch_cmd, cur_cmd;
  logic [31:0] rsp_data;

  logic        take, set_err, cap_rd, poll_step, gap_step, gap_clr;

  spi_cmd_hs u_hs (
    .clk         (clk),
    .rst_n       (rst_n),
    .launch      (launch),
    .launch_cmd  (launch_cmd),
    .m_tready    (m_tready),
    .m_data_out  (m_data_out),
    .m_validflag (m_validflag),
    .cur_cmd     (cur_cmd),
    .cmd_done    (cmd_done),
    .rsp_data    (rsp_data)
  );

  assign poll_cnt_inc = (poll_cnt == 16'hFFFF) ? poll_cnt : poll_cnt + 16'd1;

  // Each command is launched on the edge that leaves the previous step, so
  // m_validflag rises one cycle after start or after the prior completion.
  always_comb begin
    state_next = state;
    launch     = 1'b0;
    launch_cmd = '0;
    take       = 1'b0;
    set_err    = 1'b0;
    cap_rd     = 1'b0;
    poll_step  = 1'b0;
    gap_step   = 1'b0;
    gap_clr    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          take = 1'b1;
          case (op_e'(op))
            OP_READ: begin
              state_next = ST_MAIN;
              launch     = 1'b1;
              launch_cmd = make_cmd(CMD_READ, op_addr, op_wdata);
            end
            OP_PP, OP_SE: begin
              state_next = ST_WREN;
              launch     = 1'b1;
              launch_cmd = make_cmd(CMD_WREN, op_addr, op_wdata);
            end
            default: begin
              state_next = ST_FIN;
              set_err    = 1'b1;
            end
          endcase
        end
      end
      ST_WREN: begin
        if (cmd_done) begin
          state_next = ST_MAIN;
          launch     = 1'b1;
          launch_cmd = make_cmd(main_cmd(op_q), addr_q, wdata_q);
        end
      end
      ST_MAIN: begin
        if (cmd_done) begin
          if (op_q == OP_READ) begin
            cap_rd     = 1'b1;
            state_next = ST_FIN;
          end else begin
            state_next = ST_POLL;
            launch     = 1'b1;
            launch_cmd = make_cmd(CMD_RDSR, addr_q, wdata_q);
          end
        end
      end
      ST_POLL: begin
        if (cmd_done) begin
          poll_step = 1'b1;
          if (!rsp_data[0]) begin
            state_next = ST_FIN;
          end else if (poll_cnt_inc >= POLL_LIMIT) begin
            state_next = ST_FIN;
            set_err    = 1'b1;
          end else begin
            state_next = ST_GAP;
            gap_clr    = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_next = ST_POLL;
          launch     = 1'b1;
          launch_cmd = make_cmd(CMD_RDSR, addr_q, wdata_q);
        end else begin
          gap_step = 1'b1;
        end
      end
      ST_FIN: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_next;
      if (take) begin
        op_q    <= op_e'(op);
        addr_q  <= op_addr;
        wdata_q <= op_wdata;
      end
    end
  end

  // done is registered from FIN, so it lands the cycle busy drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      error <= 1'b0;
      rdata <= '0;
    end else begin
      done <= (state == ST_FIN);
      if (take) begin
        busy  <= 1'b1;
        error <= set_err;
      end else begin
        if (state == ST_FIN) busy <= 1'b0;
        if (set_err) error <= 1'b1;
      end
      if (cap_rd) rdata <= rsp_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      poll_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      if (take) poll_cnt <= '0;
      else if (poll_step) poll_cnt <= poll_cnt_inc;
      if (gap_clr) gap_cnt <= '0;
      else if (gap_step) gap_cnt <= gap_cnt + 16'd1;
    end
  end

  assign m_commtype   = cur_cmd.commtype;
  assign m_command    = cur_cmd.opcode;
  assign m_address    = cur_cmd.address;
  assign m_data_in    = cur_cmd.data_in;
  assign m_nmiso_bits = cur_cmd.nmiso_bits;
  assign m_dummy      = 4'd0;

endmodule
